// File: rtl/prng_sample_fifo_if.sv
// -----------------------------------------------------------------------------
// prng_sample_fifo_if
//
// Purpose: groups the sample-capture and consumer-handshake signals of
// prng_sample_fifo into one bundle. clk and reset stay plain module ports.
//
// Parameters: W (sample width), DEPTH (entries), AW (pointer width, derived).
//
// Signals:
//   in_data    [W-1:0]  sample from the PRNG (prng_data)
//   in_valid            sample strobe (prng_done)
//   capture_en          accept samples when high
//   flush               synchronous clear of contents and status
//   out_data   [W-1:0]  head-of-FIFO sample (0 when empty)
//   out_valid           FIFO non-empty
//   out_ready           consumer takes out_data this cycle
//   count      [AW:0]   stored entries, 0..DEPTH
//   full / empty        count == DEPTH / count == 0
//   overflow            sticky "a sample was dropped"
//   drop_count [15:0]   saturating drop counter, only with PRNG_FIFO_DROP_CNT_EN
//
// Modports: slave = FIFO side, master = producer/consumer side.
// Optional feature macro: PRNG_FIFO_DROP_CNT_EN.
// -----------------------------------------------------------------------------
interface prng_sample_fifo_if #(
  parameter int W     = 8,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
);
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         capture_en;
  logic         flush;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic [AW:0]  count;
  logic         full;
  logic         empty;
  logic         overflow;
`ifdef PRNG_FIFO_DROP_CNT_EN
  logic [15:0]  drop_count;

  modport slave (
    input  in_data, in_valid, capture_en, flush, out_ready,
    output out_data, out_valid, count, full, empty, overflow, drop_count
  );
  modport master (
    output in_data, in_valid, capture_en, flush, out_ready,
    input  out_data, out_valid, count, full, empty, overflow, drop_count
  );
`else
  modport slave (
    input  in_data, in_valid, capture_en, flush, out_ready,
    output out_data, out_valid, count, full, empty, overflow
  );
  modport master (
    output in_data, in_valid, capture_en, flush, out_ready,
    input  out_data, out_valid, count, full, empty, overflow
  );
`endif
endinterface

// File: rtl/prng_sample_fifo.sv
// -----------------------------------------------------------------------------
// prng_sample_fifo
//
// Purpose: first-word-fall-through buffer between the free-running 8-bit LCG
// PRNG and its consumers. One sample is captured per cycle with in_valid and
// capture_en high; the head sample is presented on out_data/out_valid and
// popped with out_ready.
//
// Ports:
//   clk    rising-edge system clock
//   reset  asynchronous, active-low reset
//   bus    prng_sample_fifo_if.slave (data in, handshake out, status)
//
// Optional feature macro: PRNG_FIFO_DROP_CNT_EN adds bus.drop_count, a 16-bit
// saturating count of dropped samples cleared by reset and flush.
// -----------------------------------------------------------------------------
module prng_sample_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  prng_sample_fifo_if.slave     bus
);
  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;

  logic full_w, empty_w, push_req, pop, push, drop;

  // Status is derived from the registered count only, so nothing on in_*
  // reaches out_* combinationally.
  assign full_w   = (count_q == DEPTH_C);
  assign empty_w  = (count_q == '0);

  assign push_req = bus.in_valid & bus.capture_en & ~bus.flush;
  assign pop      = ~empty_w & bus.out_ready & ~bus.flush;
  // A full FIFO can still accept a sample when the head leaves the same cycle.
  assign push     = push_req & (~full_w | pop);
  assign drop     = push_req & full_w & ~pop;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (bus.flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      if (drop) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is deliberately not reset; count gates what is visible.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.in_data;
  end

  assign bus.out_data  = empty_w ? '0 : mem_q[rd_ptr_q];
  assign bus.out_valid = ~empty_w;
  assign bus.count     = count_q;
  assign bus.full      = full_w;
  assign bus.empty     = empty_w;
  assign bus.overflow  = overflow_q;

`ifdef PRNG_FIFO_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (bus.flush)
      drop_cnt_d = '0;
    else if (drop && drop_cnt_q != 16'hFFFF)
      drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) drop_cnt_q <= '0;
    else        drop_cnt_q <= drop_cnt_d;
  end

  assign bus.drop_count = drop_cnt_q;
`endif
endmodule

// File: doc/prng_sample_fifo.md
Name: prng_sample_fifo

Overview:
- Downstream buffer for the 8-bit LCG PRNG.
- Captures one sample per cycle in which the PRNG signals `prng_done` and capture is enabled.
- Stores samples in a small first-word-fall-through (FWFT) FIFO.
- Delivers samples to consumers (stochastic rounding, dropout masks) over a valid/ready handshake, decoupling consumer stalls from the free-running generator.

Parameters:
- W, 8, sample width; matches PRNG output width.
- DEPTH, 8, FIFO entries; must be a power of two and ≥ 2.
- AW, $clog2(DEPTH), pointer width; derived, not to be overridden.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_data  input  W  sample from the PRNG (`prng_data`).
- in_valid  input  1  sample-valid strobe (`prng_done`).
- capture_en  input  1  high = accept samples; low = ignore in_valid.
- flush  input  1  synchronous clear of contents and status.
- out_data  output  W  head-of-FIFO sample.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts out_data this cycle.
- count  output  AW+1  number of stored entries, 0..DEPTH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- overflow  output  1  sticky: a sample was dropped because the FIFO was full.

Behaviour:
- Reset (reset low, asynchronous): rd_ptr = wr_ptr = 0, count = 0, overflow = 0.
  - Outputs during reset: out_valid = 0, empty = 1, full = 0, out_data = 0.
  - Memory contents are not reset.
- Definitions:
  - push_req = in_valid & capture_en & !flush.
  - pop = out_valid & out_ready & !flush.
  - push = push_req & (!full | pop).
- Push: mem[wr_ptr] <= in_data; wr_ptr increments modulo DEPTH (natural wrap of AW bits).
- Pop: rd_ptr increments modulo DEPTH.
- count update: +1 on push only, −1 on pop only, unchanged on both or neither.
- Latency:
  - A sample pushed at edge N appears on out_data/out_valid after edge N (one cycle in-to-out).
  - No combinational path from in_* to out_*.
- FWFT read:
  - out_data = mem[rd_ptr] when !empty, otherwise 0.
  - out_valid = !empty.
  - full, empty and out_valid derive from registered count only.
- Handshake:
  - out_data and out_valid must remain stable while out_valid & !out_ready.
  - out_ready is ignored while empty.
- Boundary conditions:
  - Empty + push_req + out_ready: push occurs, no pop; count becomes 1.
  - Full + push_req + pop in the same cycle: both occur; count stays DEPTH; no drop.
  - Full + push_req without pop: sample dropped; overflow <= 1; pointers and count unchanged.
  - Overflow stays set until flush or reset; further drops do not clear it.
- Flush (synchronous, highest priority after reset):
  - Next edge: pointers = 0, count = 0, overflow = 0.
  - A push or pop requested in the flush cycle is discarded.
- Reset asserted mid-stream: contents are lost immediately; the first post-reset sample is the first one captured after reset deasserts.
- capture_en low: in_valid is ignored, no overflow is flagged, and draining continues normally.

Optional Feature:
- Macro: PRNG_FIFO_DROP_CNT_EN.
- Defined:
  - Adds output port `drop_count` [15:0]: a count of dropped samples, incremented on each full-without-pop push_req.
  - Saturates at 16'hFFFF.
  - Cleared to 0 by reset and by flush.
  - `overflow` behaves as without the macro.
- Not defined:
  - The port and counter are absent.
  - Only the sticky `overflow` bit reports drops.

Test Plan:
- Reset, then push 0x2A, 0x07, 0x24 on consecutive cycles with out_ready = 0.
  - Required: count = 3, out_data = 0x2A, out_valid = 1, empty = 0.
- From that state, hold out_ready = 1 with no pushes.
  - Required: out_data sequence 0x2A, 0x07, 0x24.
  - Afterwards: empty = 1, out_data = 0, count = 0.
- Push 9 samples (0x01..0x09) with out_ready = 0, DEPTH = 8.
  - Required: full = 1, overflow = 1, count = 8.
  - Drain yields 0x01..0x08; 0x09 is absent.
  - With PRNG_FIFO_DROP_CNT_EN: drop_count = 1.
- While full, assert in_valid and out_ready together for 20 cycles.
  - Required: count stays 8, overflow does not newly set, and outputs follow input order across pointer wrap.
- Fill with 5 samples, then assert flush together with in_valid and out_ready.
  - Required next cycle: count = 0, empty = 1, overflow = 0, and the flush-cycle sample is not stored.
- Push 4 samples, then drive reset low asynchronously mid-cycle.
  - Required: out_valid drops to 0 immediately.
  - After release, pushing 0xA5 gives out_data = 0xA5 with count = 1.
